// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } hz_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam int          REG_W_DEF = 3;

endpackage

// File: rtl/hazard_load_use_det.sv
// Combinational load-use compare: the instruction in ID reads the register a load in EX is writing.
module hazard_load_use_det
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rd,
  output logic             load_use
);

  assign load_use = id_ex_mem_read &
                    ((id_uses_rs & (id_rs == id_ex_rd)) |
                     (id_uses_rt & (id_rt == id_ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Mealy control outputs, flush window, sticky halt.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             ex_redirect,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             id_halt,
  output logic             pc_we,
  output logic             if_id_hold,
  output logic             if_id_nop,
  output logic             id_ex_bubble,
  output logic             freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam int                FCNT_W      = $clog2(FLUSH_DEPTH) + 1;
  localparam logic [FCNT_W-1:0] FCNT_ONE    = FCNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_LOAD   = FCNT_W'(FLUSH_DEPTH - 1);
  localparam hz_state_e         REDIR_STATE = (FLUSH_DEPTH > 1) ? FLUSH : RUN;

  hz_state_e         state_r, state_nxt_s;
  logic [FCNT_W-1:0] fcnt_r, fcnt_nxt_s;
  logic              load_use_s;

  hazard_load_use_det #(.REG_W(REG_W)) u_load_use_det (
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .load_use       (load_use_s)
  );

  // Output decode and next-state selection in priority order
  always_comb begin
    pc_we        = 1'b0;
    if_id_hold   = 1'b0;
    if_id_nop    = 1'b0;
    id_ex_bubble = 1'b0;
    freeze       = 1'b0;
    halted       = 1'b0;
    state_nxt_s  = state_r;
    fcnt_nxt_s   = fcnt_r;
    if (rst) begin
      if_id_nop    = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state_r)
        HALT: begin
          halted       = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
        end
        FLUSH: begin
          if (dmem_stall) begin
            freeze = 1'b1;
          end else if (ex_redirect) begin
            pc_we        = 1'b1;
            if_id_nop    = 1'b1;
            id_ex_bubble = 1'b1;
            fcnt_nxt_s   = FCNT_LOAD;
          end else begin
            // ID holds a NOP here, so load-use and HALT cannot be genuine
            pc_we       = ~imem_stall;
            if_id_nop   = 1'b1;
            fcnt_nxt_s  = fcnt_r - FCNT_ONE;
            state_nxt_s = (fcnt_r == FCNT_ONE) ? RUN : FLUSH;
          end
        end
        RUN: begin
          if (dmem_stall) begin
            freeze = 1'b1;
          end else if (ex_redirect) begin
            pc_we        = 1'b1;
            if_id_nop    = 1'b1;
            id_ex_bubble = 1'b1;
            fcnt_nxt_s   = FCNT_LOAD;
            state_nxt_s  = REDIR_STATE;
          end else if (load_use_s) begin
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (imem_stall) begin
            if_id_nop = 1'b1;
          end else if (id_halt) begin
            if_id_hold  = 1'b1;
            state_nxt_s = HALT;
          end else begin
            pc_we = 1'b1;
          end
        end
        default: begin
          state_nxt_s = RUN;
          fcnt_nxt_s  = {FCNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and flush counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      fcnt_r  <= {FCNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      fcnt_r  <= fcnt_nxt_s;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_evt_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Only stalls that actually take effect in RUN are counted
  assign stall_evt_s = ~rst & (state_r == RUN) & ~dmem_stall & ~ex_redirect &
                       (load_use_s | imem_stall);

  // Saturating perf counters; frozen cycles never raise either event
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (if_id_nop && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign flush_cycles = flush_cnt_r;
`else
  assign stall_cycles = {CNT_W{1'b0}};
  assign flush_cycles = {CNT_W{1'b0}};
`endif

endmodule
